// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and single-outstanding instruction fetch, handing instructions to decode via valid/stall
module pc_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0,
  parameter int PC_STEP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, instr_pc_q, instr_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    instr_pc_d = instr_pc_q;
    if (redirect_valid) begin
      state_d = FETCH;
      pc_d = redirect_pc;
    end else if (state_q == IDLE) begin
      state_d = FETCH;
    end else if (state_q == FETCH && imem_ack) begin
      state_d = VALID;
      instr_d = imem_rdata;
      instr_pc_d = pc_q;
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end else if (state_q == VALID && !stall) begin
      state_d = FETCH;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= ADDR_W'(RESET_PC);
      instr_q <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end
  assign imem_req = state_q == FETCH;
  assign instr_valid = state_q == VALID;
  assign imem_addr = pc_q;
  assign pc = pc_q;
  assign instr = instr_q;
  assign instr_pc = instr_pc_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed stimulus with a queue-based scoreboard checking every instruction presented to decode
module tb_pc_fetch_unit;
  logic clk = 0, rst = 1, stall = 0, redirect_valid = 0, imem_ack = 0;
  logic [7:0] redirect_pc = 0;
  logic imem_req, instr_valid;
  logic [7:0] imem_addr, instr_pc, pc;
  logic [15:0] imem_rdata, instr;
  logic [23:0] exp_q[$];
  logic [23:0] last;
  logic held = 0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign imem_rdata = 16'hA000 | {8'h00, imem_addr};
  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .pc(pc)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rst) held = 0;
    else begin
      if (instr_valid && !held) begin
        if (exp_q.size() == 0) chk("unexpected_instr", {8'h0, instr, instr_pc}, 32'hFFFFFFFF);
        else begin
          last = exp_q.pop_front();
          chk("sb_instr", {8'h0, instr, instr_pc}, {8'h0, last});
        end
      end else if (instr_valid && held) chk("sb_hold", {8'h0, instr, instr_pc}, {8'h0, last});
      held = instr_valid && stall && !redirect_valid;
    end
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    rst = 0;
    imem_ack = 1;
    exp_q.push_back(24'hA000_00);
    exp_q.push_back(24'hA001_01);
    exp_q.push_back(24'hA002_02);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_req", imem_req, 1);
      chk("t1_addr", imem_addr, i);
      step();
      chk("t1_valid", instr_valid, 1);
      chk("t1_pc", pc, i + 1);
    end
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_valid", instr_valid, 1);
      chk("t2_instr", instr, 16'hA002);
      chk("t2_instr_pc", instr_pc, 2);
      chk("t2_pc", pc, 3);
      chk("t2_req", imem_req, 0);
    end
    stall = 0;
    exp_q.push_back(24'hA003_03);
    exp_q.push_back(24'hA004_04);
    step();
    chk("t2_resume_addr", imem_addr, 3);
    chk("t2_resume_req", imem_req, 1);
    step();
    step();
    chk("t2_addr4", imem_addr, 4);
    step();
    chk("t2_pc5", pc, 5);
    imem_ack = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_req", imem_req, 1);
      chk("t3_addr", imem_addr, 5);
      chk("t3_valid", instr_valid, 0);
    end
    exp_q.push_back(24'hA005_05);
    imem_ack = 1;
    step();
    chk("t3_valid", instr_valid, 1);
    chk("t3_pc", pc, 6);
    chk("t3_instr_pc", instr_pc, 5);
    exp_q.push_back(24'hA006_06);
    step();
    step();
    step();
    chk("t4_addr7", imem_addr, 7);
    redirect_valid = 1;
    redirect_pc = 8'h40;
    step();
    redirect_valid = 0;
    chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 8'h40);
    chk("t4_valid", instr_valid, 0);
    chk("t4_instr_pc_kept", instr_pc, 6);
    exp_q.push_back(24'hA040_40);
    step();
    chk("t4_instr_pc", instr_pc, 8'h40);
    chk("t4_pc", pc, 8'h41);
    stall = 1;
    redirect_valid = 1;
    redirect_pc = 8'h10;
    step();
    redirect_valid = 0;
    stall = 0;
    chk("t5_valid", instr_valid, 0);
    chk("t5_addr", imem_addr, 8'h10);
    chk("t5_req", imem_req, 1);
    exp_q.push_back(24'hA010_10);
    step();
    chk("t5_instr_pc", instr_pc, 8'h10);
    redirect_valid = 1;
    redirect_pc = 8'hFF;
    step();
    redirect_valid = 0;
    chk("t6_addr", imem_addr, 8'hFF);
    exp_q.push_back(24'hA0FF_FF);
    step();
    chk("t6_instr_pc", instr_pc, 8'hFF);
    chk("t6_wrap_pc", pc, 0);
    step();
    chk("t6_pending", imem_req, 1);
    rst = 1;
    step();
    chk("t6_rst_pc", pc, 0);
    chk("t6_rst_req", imem_req, 0);
    chk("t6_rst_valid", instr_valid, 0);
    chk("t6_rst_instr", instr, 0);
    chk("t6_rst_instr_pc", instr_pc, 0);
    rst = 0;
    imem_ack = 0;
    step();
    chk("t6_post_req", imem_req, 1);
    chk("t6_post_addr", imem_addr, 0);
    repeat (2) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and instruction-fetch stage of the mini CPU.
It holds the PC and issues single-outstanding requests to instruction memory.
It presents each fetched instruction, with its address, to decode through a valid/stall handshake.
It consumes the next-PC select-mux output (redirect_pc, with redirect_valid as the mux select) from the branch/jump logic.

Parameters:
ADDR_W, 8, PC and instruction-memory address width
INSTR_W, 16, instruction word width
RESET_PC, 0, PC value loaded on reset
PC_STEP, 1, PC increment per fetched instruction (word-addressed)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  decode not ready; hold current instruction
redirect_valid  input  1  load redirect_pc as next fetch address (branch/jump taken)
redirect_pc  input  ADDR_W  redirect target from next-PC mux
imem_req  output  1  instruction memory request
imem_addr  output  ADDR_W  request address, equals pc
imem_ack  input  1  memory response valid; counts only while imem_req=1
imem_rdata  input  INSTR_W  instruction word, sampled when imem_req & imem_ack
instr_valid  output  1  instr/instr_pc hold a valid instruction for decode
instr  output  INSTR_W  fetched instruction
instr_pc  output  ADDR_W  address of instr
pc  output  ADDR_W  current fetch PC

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); no asynchronous reset anywhere.
- Reset: pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr=0, instr_pc=0. rst overrides all other inputs in the same cycle, including mid-request or mid-stall. Any in-flight ack is discarded.
- imem_addr = pc (combinational). imem_req = (state==FETCH), registered via state.
- States: IDLE, FETCH, VALID.
- IDLE: entered only from reset. Next cycle goes to FETCH unconditionally. If redirect_valid=1 while in IDLE, pc<=redirect_pc.
- FETCH: imem_req=1, and imem_addr stays stable until ack or redirect. On imem_ack=1: instr<=imem_rdata, instr_pc<=pc, pc<=pc+PC_STEP (mod 2^ADDR_W, wraps silently), next state VALID. With no ack, stay in FETCH and keep waiting indefinitely (no timeout).
- VALID: instr_valid=1; instr and instr_pc are held constant.
  - stall=0: the instruction is consumed this cycle; next state FETCH, instr_valid=0 next cycle.
  - stall=1: stay in VALID with all outputs unchanged.
- Redirect has priority over ack and stall, in every non-reset state:
  - pc<=redirect_pc, next state FETCH, instr_valid=0 next cycle.
  - In FETCH, an imem_ack in the same cycle is discarded: instr and instr_pc are not updated, and pc takes redirect_pc, not pc+PC_STEP.
  - In VALID with stall=1, the held instruction is flushed.
- Latency: ack in the first FETCH cycle gives instr_valid on the next cycle. Peak throughput is 1 instruction per 2 cycles.
- imem_ack while imem_req=0 is ignored. At most one request is outstanding.
- instr and instr_pc keep their last values when instr_valid=0; they change only on an accepted ack.

Test Plan:
1. Reset then zero-wait memory (ack tied 1, rdata = 16'hA000|addr), stall=0 -> imem_addr 0,1,2,... on alternate cycles; instr_valid pulses carry instr=A000,A001,A002 with instr_pc=0,1,2.
2. Stall: set stall=1 for 3 cycles while instr_valid=1 (instr_pc=2) -> instr, instr_pc and pc=3 unchanged, imem_req=0 throughout. After release, next fetch addr=3.
3. Delayed ack: ack asserted 4 cycles after imem_req rises at addr 5 -> imem_req held high and imem_addr=5 for all 4 cycles. instr_valid rises the cycle after ack; pc=6.
4. Redirect with simultaneous ack in FETCH at addr 7, redirect_pc=8'h40 -> that ack's data is never presented. Next request addr=0x40; the following instr_pc=0x40 and pc=0x41 after its ack.
5. Redirect in VALID with stall=1 (redirect_pc=8'h10) -> instr_valid=0 next cycle; fetch resumes at 0x10.
6. Wrap and reset: redirect to 8'hFF, ack -> instr_pc=FF, pc=00. Assert rst during a pending FETCH -> next cycle pc=RESET_PC, imem_req=0, instr_valid=0; the ack in the rst cycle is ignored.
